// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-unit control/table/status bundle between the sequencer and inst_fetch.
// Ports (signals):
//   start, stall, jump, branch_en, taken, imm      - control from sequencer/decoder/ALU
//   tbl_we, tbl_addr, tbl_data                      - target-table write port
//   prog_len                                        - program length (0 means 2**PC_W)
//   prog_ctr, running, done                         - fetch status back to the sequencer
//   cycle_count                                     - only with INST_FETCH_CYCLE_COUNT_EN
// Modports: master drives control, slave is the fetch unit.
interface inst_fetch_if #(
    parameter int PC_W   = 10,
    parameter int TBL_AW = 5
);
    logic              start;
    logic              stall;
    logic              jump;
    logic              branch_en;
    logic              taken;
    logic [4:0]        imm;
    logic              tbl_we;
    logic [TBL_AW-1:0] tbl_addr;
    logic [PC_W-1:0]   tbl_data;
    logic [PC_W-1:0]   prog_len;
    logic [PC_W-1:0]   prog_ctr;
    logic              running;
    logic              done;
`ifdef INST_FETCH_CYCLE_COUNT_EN
    logic [15:0]       cycle_count;
    modport master (
        output start, stall, jump, branch_en, taken, imm, tbl_we, tbl_addr, tbl_data, prog_len,
        input  prog_ctr, running, done, cycle_count
    );
    modport slave (
        input  start, stall, jump, branch_en, taken, imm, tbl_we, tbl_addr, tbl_data, prog_len,
        output prog_ctr, running, done, cycle_count
    );
`else
    modport master (
        output start, stall, jump, branch_en, taken, imm, tbl_we, tbl_addr, tbl_data, prog_len,
        input  prog_ctr, running, done
    );
    modport slave (
        input  start, stall, jump, branch_en, taken, imm, tbl_we, tbl_addr, tbl_data, prog_len,
        output prog_ctr, running, done
    );
`endif
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: program-counter sequencer with IDLE/RUN/DONE FSM and a jump-target table.
// Ports: clk, rst (sync, active-high); bus (inst_fetch_if.slave) carrying start/stall/jump/
//   branch_en/taken/imm, table write port, prog_len, and prog_ctr/running/done outputs.
// Optional: INST_FETCH_CYCLE_COUNT_EN adds a saturating 16-bit cycle_count on the bus.
module inst_fetch #(
    parameter int PC_W   = 10,
    parameter int TBL_AW = 5
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, target, last;
    logic [PC_W-1:0] tbl_q [2**TBL_AW];
    logic            running_q, done_q, redirect, at_end, tbl_wr;
    always_comb begin
        target   = tbl_q[bus.imm[TBL_AW-1:0]];
        last     = bus.prog_len - PC_W'(1);
        // prog_len==0 stands for a full 2**PC_W program, which never ends by length
        at_end   = (bus.prog_len != '0) && (pc_q == last);
        redirect = bus.jump | (bus.branch_en & bus.taken);
        tbl_wr   = bus.tbl_we && (state_q != RUN);
        state_d  = state_q;
        pc_d     = pc_q;
        if (state_q == RUN) begin
            if (!bus.stall) begin
                pc_d    = redirect ? target : at_end ? pc_q : pc_q + PC_W'(1);
                state_d = (!redirect && at_end) ? DONE : RUN;
            end
        end else if (bus.start) begin
            state_d = RUN;
            pc_d    = '0;
        end
    end
    // status flags are registered from the next state so they line up with prog_ctr
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**TBL_AW; i++) tbl_q[i] <= '0;
        end else if (tbl_wr) begin
            tbl_q[bus.tbl_addr] <= bus.tbl_data;
        end
    end
    assign bus.prog_ctr = pc_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
`ifdef INST_FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb
        cnt_d = (state_q != RUN && bus.start) ? 16'd0 :
                (state_q == RUN && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign bus.cycle_count = cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch driving directed program-flow scenarios.
module tb_inst_fetch;
    typedef struct {
        string       tag;
        logic [9:0]  pc;
        logic        run;
        logic        done;
    } exp_t;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];
    inst_fetch_if #(.PC_W(10), .TBL_AW(5)) bus();
    inst_fetch #(.PC_W(10), .TBL_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    // push the expectation for the inputs currently driven, clock once, then pop and compare
    task automatic step(input string tag, input logic [9:0] pc, input logic run, input logic dn);
        exp_t e;
        sb.push_back('{tag, pc, run, dn});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"}, 32'(bus.prog_ctr), 32'(e.pc));
        chk({e.tag, ".run"}, 32'(bus.running), 32'(e.run));
        chk({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
        rst = 0;
        bus.start = 0;
        bus.stall = 0;
        bus.jump = 0;
        bus.branch_en = 0;
        bus.taken = 0;
        bus.tbl_we = 0;
    endtask
    initial begin
        checks = 0;
        failures = 0;
        clk = 0;
        rst = 1;
        bus.start = 1;
        bus.stall = 0;
        bus.jump = 0;
        bus.branch_en = 0;
        bus.taken = 0;
        bus.imm = 0;
        bus.tbl_we = 0;
        bus.tbl_addr = 0;
        bus.tbl_data = 0;
        bus.prog_len = 10'd4;
        #2;
        step("rst_start", 10'h000, 0, 0);
        bus.tbl_we = 1; bus.tbl_addr = 5; bus.tbl_data = 10'h020;
        step("wr5", 10'h000, 0, 0);
        bus.tbl_we = 1; bus.tbl_addr = 2; bus.tbl_data = 10'h007;
        step("wr2", 10'h000, 0, 0);
        bus.start = 1;
        step("start", 10'h000, 1, 0);
        step("seq1", 10'h001, 1, 0);
        step("seq2", 10'h002, 1, 0);
        step("seq3", 10'h003, 1, 0);
        step("end", 10'h003, 0, 1);
        step("hold", 10'h003, 0, 1);
        bus.prog_len = 10'h022; bus.start = 1;
        step("restart", 10'h000, 1, 0);
        step("r1", 10'h001, 1, 0);
        step("r2", 10'h002, 1, 0);
        bus.stall = 1; bus.jump = 1; bus.imm = 5;
        step("stall_jump", 10'h002, 1, 0);
        step("unstall", 10'h003, 1, 0);
        bus.branch_en = 1; bus.imm = 2; bus.taken = 0;
        step("br_nt", 10'h004, 1, 0);
        bus.branch_en = 1; bus.taken = 1;
        step("br_t", 10'h007, 1, 0);
        bus.tbl_we = 1; bus.tbl_addr = 5; bus.tbl_data = 10'h111; bus.start = 1;
        step("run_wr_start", 10'h008, 1, 0);
        bus.jump = 1; bus.imm = 5;
        step("jump", 10'h020, 1, 0);
        bus.taken = 1; bus.imm = 2;
        step("taken_only", 10'h021, 1, 0);
        bus.jump = 1; bus.imm = 5;
        step("jump_last", 10'h020, 1, 0);
        step("to_last", 10'h021, 1, 0);
        step("len_end", 10'h021, 0, 1);
        bus.jump = 1;
        step("done_jump", 10'h021, 0, 1);
        bus.tbl_we = 1; bus.tbl_addr = 5; bus.tbl_data = 10'h030;
        step("done_wr", 10'h021, 0, 1);
        bus.start = 1;
        step("restart2", 10'h000, 1, 0);
        bus.jump = 1; bus.imm = 5;
        step("new_tgt", 10'h030, 1, 0);
        rst = 1; bus.start = 1; bus.jump = 1;
        step("mid_rst", 10'h000, 0, 0);
        bus.tbl_we = 1; bus.tbl_addr = 3; bus.tbl_data = 10'h3FE;
        step("wr3", 10'h000, 0, 0);
        bus.prog_len = 10'h000; bus.start = 1;
        step("start_len0", 10'h000, 1, 0);
        bus.jump = 1; bus.imm = 5;
        step("clr5", 10'h000, 1, 0);
        bus.branch_en = 1; bus.taken = 1; bus.imm = 2;
        step("clr2", 10'h000, 1, 0);
        bus.jump = 1; bus.imm = 3;
        step("wrap_j", 10'h3FE, 1, 0);
        step("wrap1", 10'h3FF, 1, 0);
        step("wrap2", 10'h000, 1, 0);
`ifdef INST_FETCH_CYCLE_COUNT_EN
        rst = 1;
        step("cc_rst", 10'h000, 0, 0);
        chk("cc_rst", 32'(bus.cycle_count), 32'd0);
        bus.prog_len = 10'd4; bus.start = 1;
        step("cc_start", 10'h000, 1, 0);
        step("cc1", 10'h001, 1, 0);
        bus.stall = 1;
        step("cc_stall", 10'h001, 1, 0);
        step("cc2", 10'h002, 1, 0);
        step("cc3", 10'h003, 1, 0);
        step("cc_done", 10'h003, 0, 1);
        chk("cc_done", 32'(bus.cycle_count), 32'd5);
        step("cc_hold", 10'h003, 0, 1);
        chk("cc_hold", 32'(bus.cycle_count), 32'd5);
        bus.start = 1;
        step("cc_restart", 10'h000, 1, 0);
        chk("cc_clear", 32'(bus.cycle_count), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
